// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acq_sequencer
// Description : Host-driven acquisition controller for the ramp -> async FIFO
//               -> BTPipeOut capture path. A rising edge on start flushes the
//               transfer FIFO, waits a settle window, then enables the ramp
//               source for a fixed number of sample ticks (or continuously
//               when sample_count is 0) until done or aborted.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      system clock (sys_clk)
//   reset        in   1      asynchronous, active-high reset
//   start        in   1      host level; rising edge starts a run
//   abort        in   1      host level; while high forces return to IDLE
//   sample_count in   CNT_W  samples per run (0 = continuous), latched at start
//   sample_tick  in   1      one-cycle strobe per ramp sample
//   fifo_full    in   1      FIFO write-side full flag
//   fifo_rst     out  1      transfer FIFO reset
//   ramp_reset   out  1      ramp source reset, active-high
//   ramp_enable  out  1      ramp source enable
//   busy         out  1      high in any state except IDLE
//   done         out  1      sticky: run completed normally
//   overflow     out  1      sticky: fifo_full seen with sample_tick in ACQUIRE
//   samples_done out  CNT_W  ticks counted in current/last run
// Configuration
//   ACQ_SEQ_OVF_STOP_EN : when defined, an overflow event in ACQUIRE ends the
//                         run without counting the dropped tick.
// ============================================================================
module acq_sequencer #(
    parameter int CNT_W         = 16,
    parameter int FLUSH_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] sample_count,
    input  logic             sample_tick,
    input  logic             fifo_full,
    output logic             fifo_rst,
    output logic             ramp_reset,
    output logic             ramp_enable,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] samples_done
);

    // Phase counter is shared by FLUSH and SETTLE, so size it for the longer one.
    localparam int c_PHASE_MAX = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
    localparam int c_PH_W      = $clog2(c_PHASE_MAX + 1);

    localparam logic [c_PH_W-1:0] c_FLUSH_LAST  = c_PH_W'(FLUSH_CYCLES - 1);
    localparam logic [c_PH_W-1:0] c_SETTLE_LAST = c_PH_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLUSH   = 2'd1,
        S_SETTLE  = 2'd2,
        S_ACQUIRE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_startQ;
    logic [c_PH_W-1:0] r_phaseCnt;
    logic [CNT_W-1:0]  r_target;

    logic              w_startEdge;
    logic [CNT_W-1:0]  w_nextCount;
    logic              w_hitTarget;

    assign w_startEdge = start & ~r_startQ;
    // Natural wrap of the adder gives the continuous-mode rollover; in counted
    // mode the run ends at the target before any wrap can occur.
    assign w_nextCount = samples_done + 1'b1;
    assign w_hitTarget = (r_target != '0) && (w_nextCount == r_target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_startQ     <= 1'b0;
            r_phaseCnt   <= '0;
            r_target     <= '0;
            fifo_rst     <= 1'b1;
            ramp_reset   <= 1'b1;
            ramp_enable  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            samples_done <= '0;
        end else begin
            r_startQ <= start;

            if (abort) begin
                // Abort outranks everything, including a start edge or the
                // final tick of a run; sticky flags and the count are kept.
                r_state     <= S_IDLE;
                fifo_rst    <= 1'b0;
                ramp_reset  <= 1'b1;
                ramp_enable <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        fifo_rst    <= 1'b0;
                        ramp_reset  <= 1'b1;
                        ramp_enable <= 1'b0;
                        busy        <= 1'b0;
                        if (w_startEdge) begin
                            r_target     <= sample_count;
                            done         <= 1'b0;
                            overflow     <= 1'b0;
                            samples_done <= '0;
                            r_phaseCnt   <= '0;
                            fifo_rst     <= 1'b1;
                            busy         <= 1'b1;
                            r_state      <= S_FLUSH;
                        end
                    end

                    S_FLUSH: begin
                        if (r_phaseCnt == c_FLUSH_LAST) begin
                            r_phaseCnt <= '0;
                            fifo_rst   <= 1'b0;
                            ramp_reset <= 1'b0;
                            r_state    <= S_SETTLE;
                        end else begin
                            r_phaseCnt <= r_phaseCnt + 1'b1;
                        end
                    end

                    S_SETTLE: begin
                        if (r_phaseCnt == c_SETTLE_LAST) begin
                            r_phaseCnt  <= '0;
                            ramp_enable <= 1'b1;
                            r_state     <= S_ACQUIRE;
                        end else begin
                            r_phaseCnt <= r_phaseCnt + 1'b1;
                        end
                    end

                    S_ACQUIRE: begin
                        if (sample_tick) begin
`ifdef ACQ_SEQ_OVF_STOP_EN
                            if (fifo_full) begin
                                // Dropped tick terminates the run uncounted.
                                overflow    <= 1'b1;
                                ramp_enable <= 1'b0;
                                ramp_reset  <= 1'b1;
                                busy        <= 1'b0;
                                r_state     <= S_IDLE;
                            end else begin
                                samples_done <= w_nextCount;
                                if (w_hitTarget) begin
                                    done        <= 1'b1;
                                    ramp_enable <= 1'b0;
                                    ramp_reset  <= 1'b1;
                                    busy        <= 1'b0;
                                    r_state     <= S_IDLE;
                                end
                            end
`else
                            if (fifo_full) begin
                                overflow <= 1'b1;
                            end
                            samples_done <= w_nextCount;
                            if (w_hitTarget) begin
                                done        <= 1'b1;
                                ramp_enable <= 1'b0;
                                ramp_reset  <= 1'b1;
                                busy        <= 1'b0;
                                r_state     <= S_IDLE;
                            end
`endif
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_acq_sequencer
// Description : Directed self-checking bench for acq_sequencer (default
//               parameters). Expectations for the overflow scenario follow
//               ACQ_SEQ_OVF_STOP_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] sample_count;
    logic        sample_tick;
    logic        fifo_full;
    logic        fifo_rst;
    logic        ramp_reset;
    logic        ramp_enable;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] samples_done;

    int testCount = 0;
    int failCount = 0;

    acq_sequencer #(
        .CNT_W        (16),
        .FLUSH_CYCLES (8),
        .SETTLE_CYCLES(16)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .sample_count(sample_count),
        .sample_tick (sample_tick),
        .fifo_full   (fifo_full),
        .fifo_rst    (fifo_rst),
        .ramp_reset  (ramp_reset),
        .ramp_enable (ramp_enable),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .samples_done(samples_done)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One tick pulse spanning one clock, then idle so ticks repeat every 'period' clocks.
    task automatic pulseTick(input logic full, input int period);
        @(negedge clk);
        sample_tick = 1'b1;
        fifo_full   = full;
        @(negedge clk);
        sample_tick = 1'b0;
        fifo_full   = 1'b0;
        repeat (period - 2) @(negedge clk);
    endtask

    // Produces a fresh start edge with the given count.
    task automatic startRun(input logic [15:0] n);
        @(negedge clk);
        start        = 1'b0;
        sample_count = n;
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic waitEnable(input string tag);
        int n = 0;
        while (!ramp_enable && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkVal(tag, ramp_enable, 1);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        sample_count = 16'd0;
        sample_tick  = 1'b0;
        fifo_full    = 1'b0;

        // ---------------- reset state ----------------
        #1;
        checkVal("rst_fifo_rst", fifo_rst, 1);
        checkVal("rst_ramp_reset", ramp_reset, 1);
        checkVal("rst_ramp_enable", ramp_enable, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_flags", {done, overflow}, 0);
        checkVal("rst_samples", samples_done, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("rel_fifo_rst_hold", fifo_rst, 1);
        @(negedge clk);
        checkVal("idle_fifo_rst", fifo_rst, 0);
        checkVal("idle_ramp_reset", ramp_reset, 1);

        // ---------------- counted run, N=5, with ignored start in SETTLE ----------------
        @(negedge clk);
        sample_count = 16'd5;
        start        = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                checkVal("flush_fifo_rst", fifo_rst, 1);
                checkVal("flush_busy", busy, 1);
            end
            if (e == 3) start = 1'b0;
            if (e == 8) checkVal("flush_last_fifo_rst", fifo_rst, 1);
            if (e == 9) begin
                checkVal("settle_fifo_rst", fifo_rst, 0);
                checkVal("settle_ramp_reset", ramp_reset, 0);
            end
            if (e == 12) start = 1'b1;   // second edge while settling
            if (e == 24) checkVal("enable_at_24", ramp_enable, 0);
            if (e == 25) checkVal("enable_at_25", ramp_enable, 1);
        end
        for (int i = 1; i <= 5; i++) begin
            pulseTick(1'b0, 4);
            if (i == 4) begin
                checkVal("n5_mid_samples", samples_done, 4);
                checkVal("n5_mid_busy", busy, 1);
            end
        end
        checkVal("n5_done", done, 1);
        checkVal("n5_busy", busy, 0);
        checkVal("n5_enable", ramp_enable, 0);
        checkVal("n5_samples", samples_done, 5);
        pulseTick(1'b0, 4);
        checkVal("n5_extra_tick", samples_done, 5);

        // ---------------- continuous run, 300 ticks then abort ----------------
        startRun(16'd0);
        @(negedge clk);
        checkVal("cont_done_cleared", done, 0);
        checkVal("cont_samples_cleared", samples_done, 0);
        waitEnable("cont_enable_timeout");
        for (int i = 0; i < 300; i++) pulseTick(1'b0, 2);
        checkVal("cont_samples", samples_done, 300);
        checkVal("cont_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkVal("abort_busy", busy, 0);
        checkVal("abort_enable", ramp_enable, 0);
        checkVal("abort_done", done, 0);
        checkVal("abort_samples", samples_done, 300);

        // ---------------- overflow during ticks 3-4, N=10 ----------------
        startRun(16'd10);
        waitEnable("ovf_enable_timeout");
        for (int i = 1; i <= 10; i++) begin
            pulseTick((i == 3) || (i == 4), 4);
`ifdef ACQ_SEQ_OVF_STOP_EN
            if (i == 3) begin
                checkVal("ovfstop_busy", busy, 0);
                checkVal("ovfstop_samples", samples_done, 2);
                checkVal("ovfstop_overflow", overflow, 1);
                checkVal("ovfstop_done", done, 0);
                break;
            end
`endif
        end
`ifndef ACQ_SEQ_OVF_STOP_EN
        checkVal("ovf_overflow", overflow, 1);
        checkVal("ovf_done", done, 1);
        checkVal("ovf_samples", samples_done, 10);
        checkVal("ovf_busy", busy, 0);
`endif

        // ---------------- abort and start edge together ----------------
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkVal("abstart_busy", busy, 0);
        repeat (3) @(negedge clk);
        checkVal("abstart_busy_later", busy, 0);
        checkVal("abstart_fifo_rst", fifo_rst, 0);
        checkVal("abstart_overflow_kept", overflow, 1);

        // ---------------- abort on the completing tick, N=2 ----------------
        startRun(16'd2);
        @(negedge clk);
        checkVal("n2_overflow_cleared", overflow, 0);
        waitEnable("n2_enable_timeout");
        pulseTick(1'b0, 4);
        @(negedge clk);
        sample_tick = 1'b1;
        abort       = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        abort       = 1'b0;
        checkVal("n2_abort_done", done, 0);
        checkVal("n2_abort_busy", busy, 0);
        checkVal("n2_abort_samples", samples_done, 1);

        // ---------------- async reset mid-ACQUIRE ----------------
        startRun(16'd20);
        waitEnable("rstmid_enable_timeout");
        for (int i = 0; i < 7; i++) pulseTick(1'b0, 2);
        checkVal("rstmid_samples", samples_done, 7);
        #2;
        reset = 1'b1;
        #1;
        checkVal("rstmid_fifo_rst", fifo_rst, 1);
        checkVal("rstmid_ramp_reset", ramp_reset, 1);
        checkVal("rstmid_enable", ramp_enable, 0);
        checkVal("rstmid_busy", busy, 0);
        checkVal("rstmid_samples_clr", samples_done, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("rstmid_idle_fifo_rst", fifo_rst, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
